hist_eq_remap: RTL and testbench

HIST_EQ_REMAP -- requirements
Module: hist_eq_remap

---
 rtl/hist_eq_remap.sv | 224 ++++++++++++++++++++++
 tb/tb_hist_eq_remap.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hist_eq_remap.sv
// Histogram-equalisation remap: streams source words, looks each pixel up in a CDF table and
// writes the rescaled word. One pixel per clock; LANES must be at least 2 for the word prefetch.
`timescale 1ns/1ps
module hist_eq_remap #(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned LANES  = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned CDF_W  = 20
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     mode_bypass,
    input  logic [ADDR_W-1:0]        word_count,
    input  logic [ADDR_W-1:0]        src_base,
    input  logic [ADDR_W-1:0]        dst_base,
    input  logic [CDF_W-1:0]         cdf_min,
    input  logic [CDF_W-1:0]         divisor,
    output logic [ADDR_W-1:0]        src_addr,
    input  logic [LANES*PIX_W-1:0]   src_data,
    output logic [PIX_W-1:0]         cdf_addr,
    input  logic [CDF_W-1:0]         cdf_data,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [LANES*PIX_W-1:0]   wr_data,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned WORD_W = LANES * PIX_W;
    localparam int unsigned PROD_W = CDF_W + PIX_W;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [PIX_W-1:0]  PIX_MAX   = '1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StFinish} state_t;

    state_t r_state;
    state_t w_state_next;

    // Frame configuration captured at start
    logic               r_byp;
    logic [CDF_W-1:0]   r_min;
    logic [CDF_W-1:0]   r_div;

    // Fetch / issue stage
    logic [ADDR_W-1:0]  r_src_addr;
    logic [ADDR_W-1:0]  r_words_left;
    logic [1:0]         r_warm;
    logic [WORD_W-1:0]  r_word;
    logic               r_word_last;
    logic               r_issue;
    logic [LANE_W-1:0]  r_lane;

    // Lookup-return stage
    logic               r_p1_vld;
    logic [PIX_W-1:0]   r_p1_pix;
    logic [LANE_W-1:0]  r_p1_lane;
    logic               r_p1_last;

    // Output assembly
    logic [WORD_W-1:0]  r_acc;
    logic               r_wr_en;
    logic               r_wr_last;
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [WORD_W-1:0]  r_wr_data;

    logic               w_accept;
    logic               w_load;
    logic               w_issue_end;
    logic [PIX_W-1:0]   w_pix;
    logic [CDF_W-1:0]   w_diff;
    logic [PROD_W-1:0]  w_prod;
    logic [PROD_W-1:0]  w_quot;
    logic [PIX_W-1:0]   w_res;
    logic [WORD_W-1:0]  w_acc_next;

    assign w_accept    = start && (r_state == StIdle);
    // Next word is loaded either after the initial read latency or as the last lane is issued
    assign w_load      = r_warm[1] || (r_issue && (r_lane == LAST_LANE) && !r_word_last);
    assign w_issue_end = r_issue && (r_lane == LAST_LANE) && r_word_last;
    assign w_pix       = r_word[r_lane*PIX_W +: PIX_W];

    assign src_addr = r_src_addr;
    assign cdf_addr = w_pix;
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign busy     = (r_state != StIdle);
    assign done     = (r_state == StFinish);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = (word_count != '0) ? StRun : StFinish;
                end
            end
            StRun: begin
                if (w_issue_end) begin
                    w_state_next = StDrain;
                end
            end
            StDrain: begin
                if (r_wr_en && r_wr_last) begin
                    w_state_next = StFinish;
                end
            end
            StFinish: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_comb begin
        w_diff = cdf_data - r_min;
        w_prod = PROD_W'(w_diff) * PROD_W'(PIX_MAX);
        w_quot = '0;
        if (r_div != '0) begin
            w_quot = w_prod / PROD_W'(r_div);
        end
        if (r_byp) begin
            w_res = r_p1_pix;
        end else if (cdf_data < r_min) begin
            w_res = '0;
        end else if (r_div == '0) begin
            w_res = PIX_MAX;
        end else if (w_quot > PROD_W'(PIX_MAX)) begin
            w_res = PIX_MAX;
        end else begin
            w_res = w_quot[PIX_W-1:0];
        end
        w_acc_next = r_acc;
        w_acc_next[r_p1_lane*PIX_W +: PIX_W] = w_res;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_byp        <= 1'b0;
            r_min        <= '0;
            r_div        <= '0;
            r_src_addr   <= '0;
            r_words_left <= '0;
            r_warm       <= '0;
            r_word       <= '0;
            r_word_last  <= 1'b0;
            r_issue      <= 1'b0;
            r_lane       <= '0;
            r_p1_vld     <= 1'b0;
            r_p1_pix     <= '0;
            r_p1_lane    <= '0;
            r_p1_last    <= 1'b0;
            r_acc        <= '0;
            r_wr_en      <= 1'b0;
            r_wr_last    <= 1'b0;
            r_wr_ptr     <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
        end else begin
            r_wr_en   <= 1'b0;
            r_wr_last <= 1'b0;

            if (w_accept) begin
                r_byp        <= mode_bypass;
                r_min        <= cdf_min;
                r_div        <= divisor;
                r_src_addr   <= src_base;
                r_words_left <= word_count;
                r_wr_ptr     <= dst_base;
                r_warm       <= {1'b0, (word_count != '0)};
            end else begin
                r_warm <= {r_warm[0], 1'b0};
            end

            // src_addr moves to the next word right after a load, so its data is ready in time
            if (w_load) begin
                r_word       <= src_data;
                r_lane       <= '0;
                r_issue      <= 1'b1;
                r_words_left <= r_words_left - 1'b1;
                r_word_last  <= (r_words_left == ADDR_W'(1));
                if (r_words_left > ADDR_W'(1)) begin
                    r_src_addr <= r_src_addr + 1'b1;
                end
            end else if (r_issue) begin
                if (r_lane == LAST_LANE) begin
                    r_issue <= 1'b0;
                end else begin
                    r_lane <= r_lane + 1'b1;
                end
            end

            r_p1_vld  <= r_issue;
            r_p1_pix  <= w_pix;
            r_p1_lane <= r_lane;
            r_p1_last <= r_word_last;

            if (r_p1_vld) begin
                r_acc <= w_acc_next;
                if (r_p1_lane == LAST_LANE) begin
                    r_wr_en   <= 1'b1;
                    r_wr_last <= r_p1_last;
                    r_wr_data <= w_acc_next;
                    r_wr_addr <= r_wr_ptr;
                    r_wr_ptr  <= r_wr_ptr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hist_eq_remap.sv
// Bench for hist_eq_remap: default-size instance plus a 4-lane/4-bit instance, checked cycle by
// cycle against an arithmetic reference model of the remap and the frame timing.
`timescale 1ns/1ps
module tb_hist_eq_remap;

    localparam int L   = 16;
    localparam int PW  = 8;
    localparam int AW  = 16;
    localparam int CW  = 20;
    localparam int WW  = L * PW;
    localparam int SL  = 4;
    localparam int SPW = 4;
    localparam int SCW = 8;
    localparam int SWW = SL * SPW;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset_n;

    logic          start, mode_bypass;
    logic [AW-1:0] word_count, src_base, dst_base;
    logic [CW-1:0] cdf_min, divisor;
    logic [AW-1:0] src_addr;
    logic [WW-1:0] src_data;
    logic [PW-1:0] cdf_addr;
    logic [CW-1:0] cdf_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [WW-1:0] wr_data;
    logic          busy, done;

    logic           s_start, s_mode_bypass;
    logic [AW-1:0]  s_word_count, s_src_base, s_dst_base;
    logic [SCW-1:0] s_cdf_min, s_divisor;
    logic [AW-1:0]  s_src_addr;
    logic [SWW-1:0] s_src_data;
    logic [SPW-1:0] s_cdf_addr;
    logic [SCW-1:0] s_cdf_data;
    logic           s_wr_en;
    logic [AW-1:0]  s_wr_addr;
    logic [SWW-1:0] s_wr_data;
    logic           s_busy, s_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WW-1:0]  mem [int unsigned];
    logic [CW-1:0]  cdf_tab [256];
    logic [SWW-1:0] smem [int unsigned];
    logic [SCW-1:0] scdf_tab [16];

    hist_eq_remap dut (
        .clock(clock), .reset_n(reset_n), .start(start), .mode_bypass(mode_bypass),
        .word_count(word_count), .src_base(src_base), .dst_base(dst_base),
        .cdf_min(cdf_min), .divisor(divisor), .src_addr(src_addr), .src_data(src_data),
        .cdf_addr(cdf_addr), .cdf_data(cdf_data), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done)
    );

    hist_eq_remap #(.PIX_W(SPW), .LANES(SL), .ADDR_W(AW), .CDF_W(SCW)) dut_s (
        .clock(clock), .reset_n(reset_n), .start(s_start), .mode_bypass(s_mode_bypass),
        .word_count(s_word_count), .src_base(s_src_base), .dst_base(s_dst_base),
        .cdf_min(s_cdf_min), .divisor(s_divisor), .src_addr(s_src_addr),
        .src_data(s_src_data), .cdf_addr(s_cdf_addr), .cdf_data(s_cdf_data),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .busy(s_busy),
        .done(s_done)
    );

    // Synchronous-read memories
    always @(posedge clock) begin
        src_data   <= mem.exists(32'(src_addr)) ? mem[32'(src_addr)] : '0;
        cdf_data   <= cdf_tab[cdf_addr];
        s_src_data <= smem.exists(32'(s_src_addr)) ? smem[32'(s_src_addr)] : '0;
        s_cdf_data <= scdf_tab[s_cdf_addr];
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned remap(input longint unsigned c, input longint unsigned cmin,
                                              input longint unsigned dv, input longint unsigned maxv,
                                              input longint unsigned pix, input bit byp);
        longint unsigned q;
        if (byp) return pix;
        if (c < cmin) return 0;
        if (dv == 0) return maxv;
        q = (c - cmin) * maxv / dv;
        return (q > maxv) ? maxv : q;
    endfunction

    function automatic logic [WW-1:0] rand_word(input int maxp);
        logic [WW-1:0] w;
        for (int i = 0; i < L; i++) w[i*PW +: PW] = PW'($urandom_range(0, maxp));
        return w;
    endfunction

    function automatic logic [WW-1:0] mem_rd(input logic [AW-1:0] a);
        return mem.exists(32'(a)) ? mem[32'(a)] : '0;
    endfunction

    // Runs one frame on the default instance and checks every cycle until two cycles after done.
    // repulse: cycle at which start is pulsed again; abort_wr: assert reset at that write.
    task automatic run_frame(input string tag, input int wc, input logic [AW-1:0] sb,
                             input logic [AW-1:0] db, input int cmin, input int dv,
                             input bit byp, input int repulse, input int abort_wr);
        logic [WW-1:0] exp_q[$];
        logic [WW-1:0] w, e;
        int first, done_t, nwr, k;
        bit exp_en;
        first  = L + 4;
        done_t = (wc == 0) ? 1 : first + L * (wc - 1) + 1;
        for (int n = 0; n < wc; n++) begin
            w = mem_rd(sb + AW'(n));
            for (int i = 0; i < L; i++)
                e[i*PW +: PW] = PW'(remap(cdf_tab[w[i*PW +: PW]], cmin, dv, 255, w[i*PW +: PW], byp));
            exp_q.push_back(e);
        end
        @(negedge clock);
        start = 1'b1; word_count = AW'(wc); src_base = sb; dst_base = db;
        cdf_min = CW'(cmin); divisor = CW'(dv); mode_bypass = byp;
        @(negedge clock);
        start = 1'b0;
        nwr = 0;
        for (int t = 1; t <= done_t + 2; t++) begin
            if (t > 1) @(negedge clock);
            k = t - first;
            exp_en = (wc > 0) && (k >= 0) && (k % L == 0) && (k / L < wc);
            check({tag, "_ctl"}, {wr_en, done, busy}, {exp_en, t == done_t, t <= done_t});
            if (wr_en && exp_en) begin
                check({tag, "_waddr"}, wr_addr, db + AW'(nwr));
                check({tag, "_wdata"}, wr_data, exp_q[nwr]);
                nwr++;
                if (abort_wr != 0 && nwr == abort_wr) begin
                    reset_n = 1'b0;
                    return;
                end
            end
            start = (t == repulse);
            if (t == repulse) begin
                word_count = AW'(wc + 3); dst_base = ~db; mode_bypass = ~byp;
            end
        end
    endtask

    task automatic run_small(input string tag, input int wc, input logic [AW-1:0] sb,
                             input logic [AW-1:0] db, input int cmin, input int dv, input bit byp);
        logic [SWW-1:0] exp_q[$];
        logic [SWW-1:0] w, e;
        int first, done_t, nwr, k;
        bit exp_en;
        first  = SL + 4;
        done_t = (wc == 0) ? 1 : first + SL * (wc - 1) + 1;
        for (int n = 0; n < wc; n++) begin
            w = smem.exists(32'(sb + AW'(n))) ? smem[32'(sb + AW'(n))] : '0;
            for (int i = 0; i < SL; i++)
                e[i*SPW +: SPW] = SPW'(remap(scdf_tab[w[i*SPW +: SPW]], cmin, dv, 15,
                                             w[i*SPW +: SPW], byp));
            exp_q.push_back(e);
        end
        @(negedge clock);
        s_start = 1'b1; s_word_count = AW'(wc); s_src_base = sb; s_dst_base = db;
        s_cdf_min = SCW'(cmin); s_divisor = SCW'(dv); s_mode_bypass = byp;
        @(negedge clock);
        s_start = 1'b0;
        nwr = 0;
        for (int t = 1; t <= done_t + 2; t++) begin
            if (t > 1) @(negedge clock);
            k = t - first;
            exp_en = (wc > 0) && (k >= 0) && (k % SL == 0) && (k / SL < wc);
            check({tag, "_ctl"}, {s_wr_en, s_done, s_busy}, {exp_en, t == done_t, t <= done_t});
            if (s_wr_en && exp_en) begin
                check({tag, "_waddr"}, s_wr_addr, db + AW'(nwr));
                check({tag, "_wdata"}, s_wr_data, exp_q[nwr]);
                nwr++;
            end
        end
    endtask

    initial begin
        int cmin, dv, wc;
        logic [AW-1:0] sb, db;
        reset_n = 1'b0;
        start = 1'b0; mode_bypass = 1'b0; word_count = '0; src_base = '0; dst_base = '0;
        cdf_min = '0; divisor = '0;
        s_start = 1'b0; s_mode_bypass = 1'b0; s_word_count = '0; s_src_base = '0;
        s_dst_base = '0; s_cdf_min = '0; s_divisor = '0;
        for (int p = 0; p < 256; p++) cdf_tab[p] = CW'(p + 1);
        for (int p = 0; p < 16; p++) scdf_tab[p] = SCW'(200);
        repeat (3) @(negedge clock);
        check("reset_ctl", {wr_en, busy, done, src_addr, cdf_addr, wr_addr}, '0);
        check("reset_wdata", wr_data, '0);
        check("reset_small", {s_wr_en, s_busy, s_done, s_wr_addr, s_wr_data}, '0);
        reset_n = 1'b1;

        // V1: identity mapping through the CDF
        mem[32'h0100] = rand_word(255);
        run_frame("v1", 1, 16'h0100, 16'h0200, 1, 255, 1'b0, 0, 0);

        // V2: clamp below cdf_min, saturate with zero divisor
        for (int p = 0; p < 256; p++) cdf_tab[p] = CW'(p);
        mem[32'h0300] = rand_word(9);
        run_frame("v2", 1, 16'h0300, 16'h0400, 5, 0, 1'b0, 0, 0);

        // V3: bypass across the address wrap
        mem[32'hFFFF] = rand_word(255);
        mem[32'h0000] = rand_word(255);
        mem[32'h0001] = rand_word(255);
        run_frame("v3", 3, 16'hFFFF, 16'h0010, 0, 0, 1'b1, 0, 0);

        // V4: empty frame
        run_frame("v4", 0, 16'h0500, 16'h0600, 1, 1, 1'b0, 0, 0);

        // Random monotonic CDF tables and frames
        cdf_tab[0] = CW'($urandom_range(0, 4000));
        for (int p = 1; p < 256; p++) cdf_tab[p] = cdf_tab[p-1] + CW'($urandom_range(0, 4000));
        for (int r = 0; r < 4; r++) begin
            wc   = $urandom_range(1, 3);
            sb   = AW'($urandom_range(0, 16'hFFFF));
            db   = AW'($urandom_range(0, 16'hFFFF));
            cmin = int'(cdf_tab[$urandom_range(0, 20)]);
            dv   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3000)
                                                : int'(cdf_tab[255]) - cmin;
            for (int n = 0; n < wc; n++) mem[32'(sb + AW'(n))] = rand_word(255);
            run_frame("rnd", wc, sb, db, cmin, dv, ($urandom_range(0, 3) == 0), 0, 0);
        end

        // V5: ignored re-start, then reset at the second write
        for (int n = 0; n < 4; n++) mem[32'h0700 + n] = rand_word(255);
        run_frame("v5", 4, 16'h0700, 16'h0800, 10, 50000, 1'b0, 5, 2);
        #1;
        check("v5_rst_ctl", {wr_en, busy, done, src_addr, cdf_addr, wr_addr}, '0);
        check("v5_rst_wdata", wr_data, '0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clock);
            check("v5_quiet", {wr_en, busy, done}, '0);
        end
        run_frame("v5_fresh", 2, 16'h0701, 16'h0900, 10, 50000, 1'b0, 0, 0);

        // V6: small configuration, saturated quotient, then a random table
        smem[32'h0020] = 16'h3A5C;
        run_small("v6", 1, 16'h0020, 16'h0030, 50, 100, 1'b0);
        for (int p = 0; p < 16; p++) scdf_tab[p] = SCW'(p * 16 + $urandom_range(0, 15));
        smem[32'h0040] = 16'(($urandom));
        smem[32'h0041] = 16'(($urandom));
        run_small("v6_rnd", 2, 16'h0040, 16'h0050, int'(scdf_tab[2]), 180, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
